mem_stage: RTL
==============

# mem_stage

Pipeline stage directly downstream of the execute stage. It consumes the registered EX results (PC, instruction word, ALU result, store operand) and performs loads and stores on a request/grant/response data-memory port. It produces a registered, single-pulse writeback bundle for the WB stage. While a memory access is outstanding it stalls the pipeline through `ready_o`.

## Interface
- `DATA_WIDTH`, default 32 (from `riscv_cpu_pkg`): datapath width; this block is specified for 32.
- `clk_i`  in  1  clock, all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  EX bundle valid.
- `ready_o`  out  1  stage can accept; `valid_i & ready_o` is an accept.
- `pc_ex_i`  in  32  PC of the EX instruction.
- `instr_rdata_i`  in  32  instruction word; opcode [6:0], rd [11:7], funct3 [14:12].
- `alu_result_i`  in  DATA_WIDTH  ALU result; this is the effective address for loads and stores.
- `data_b_i`  in  DATA_WIDTH  store data (rs2).
- `data_req_o`  out  1  memory request.
- `data_gnt_i`  in  1  memory grant.
- `data_addr_o`  out  32  word-aligned address, {addr[31:2], 2'b00}.
- `data_we_o`  out  1  1 = store.
- `data_be_o`  out  4  byte enables.
- `data_wdata_o`  out  32  store data, lane-shifted.
- `data_rvalid_i`  in  1  response valid.
- `data_rdata_i`  in  32  response data.
- `valid_o`  out  1  one-cycle pulse per retired instruction.
- `pc_mem_o`  out  32  PC of the retired instruction.
- `instr_rdata_o`  out  32  instruction word of the retired instruction.
- `wb_data_o`  out  DATA_WIDTH  writeback value.
- `wb_rd_o`  out  5  destination register.
- `wb_we_o`  out  1  register-file write enable.
- `misaligned_o`  out  1  misaligned load/store flag; valid with `valid_o`.

## Operation
- States:
  - IDLE: `ready_o`=1.
  - REQ: `data_req_o`=1; address and write fields are driven from internal registers.
  - RESP: waiting for `data_rvalid_i`.
- IDLE, accept of a non-memory instruction:
  - Output registers are loaded. `wb_data_o` = `pc_ex_i`+4 for JAL (1101111) and JALR (1100111); otherwise `alu_result_i`.
  - `wb_we_o` = 1 for OP, OP-IMM, LUI, AUIPC, JAL and JALR when rd≠0; 0 otherwise (branch, store, system).
  - State stays IDLE.
- IDLE, accept of LOAD (0000011) or STORE (0100011), aligned:
  - Capture the request fields, PC, instruction and rd; go to REQ.
  - Byte access: `be` = 1<<a[1:0]; wdata = {4{b[7:0]}}.
  - Half access: `be` = 0011 or 1100 by a[1]; wdata = {2{b[15:0]}}.
  - Word access: `be` = 1111; wdata = b.
- Alignment rule: a half access with a[0]=1, or a word access with a[1:0]≠00, is misaligned.
  - No memory request is issued; state stays IDLE.
  - The output pulses next cycle with `misaligned_o`=1 and `wb_we_o`=0.
- REQ: hold `data_req_o` and all `data_*` outputs stable until `data_gnt_i`=1, then go to RESP.
- RESP: on `data_rvalid_i`=1, retire and go to IDLE.
  - Load extraction: select lane by a[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
  - Load writeback: `wb_we_o` = (rd≠0).
  - Store: `data_rdata_i` is ignored; `wb_we_o`=0.
- Invalid funct3 for a load/store is treated as a word access.
- `valid_o` is cleared every cycle unless a retire happens in that cycle's update. The WB stage applies no backpressure.
- `data_rvalid_i` is ignored in IDLE and REQ.

## Timing
- Reset value: every output is 0 except `ready_o`, which is 1 (state IDLE). An active `rst_ni` drops `data_req_o` asynchronously.
- Reset mid-access: the state returns to IDLE and the access is abandoned. A later stray `data_rvalid_i` has no effect.
- Latencies (accept in cycle 0, one pulse each):
  - Non-memory or misaligned instruction: `valid_o` in cycle 1.
  - Load/store with grant in cycle 1 and rvalid in cycle 2: `valid_o` in cycle 3.
  - Each grant wait cycle and each rvalid wait cycle adds one cycle.
- `ready_o`=0 from the cycle after a memory accept until the cycle after rvalid.
- Back-to-back non-memory instructions: 1 per cycle, with `valid_o` held high continuously.
- `data_rvalid_i` coincident with `data_gnt_i` while in REQ: ignored. The response is only taken in RESP.

## Test plan
- Reset with `valid_i`=1 -> all outputs 0 and `ready_o`=1. Release reset, accept ADDI rd=5 with alu=0x10 -> cycle 1: `valid_o`=1, `wb_rd_o`=5, `wb_we_o`=1, `wb_data_o`=0x10.
- SW addr 0x104, data 0xDEADBEEF, gnt after 2 wait cycles, then rvalid -> `data_be_o`=1111, `data_addr_o`=0x104, request stable over the waits, `ready_o`=0 throughout, one `valid_o` with `wb_we_o`=0.
- LB addr 0x203, rdata 0x80112233 -> `data_be_o`=1000, `wb_data_o`=0xFFFFFF80. Same access as LBU -> 0x00000080.
- LH addr 0x102, rdata 0x8001_1234 -> `be`=1100, `wb_data_o`=0xFFFF8001. LHU -> 0x00008001.
- LW addr 0x101 -> no `data_req_o`; cycle 1: `valid_o`=1, `misaligned_o`=1, `wb_we_o`=0.
- Load granted, reset asserted in RESP, then rvalid pulse after release -> `data_req_o`=0 at once, state IDLE, no `valid_o` produced. JAL at PC 0x40, rd=1 -> `wb_data_o`=0x44.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory pipeline stage. Consumes registered EX results, performs
//            loads/stores over a req/gnt/rvalid data port, and emits a
//            single-cycle registered writeback bundle. Stalls upstream via
//            ready_o while an access is outstanding.
// Ports    : clk_i, rst_ni (async, active-low)
//            EX side   : valid_i, ready_o, pc_ex_i, instr_rdata_i,
//                        alu_result_i (effective address), data_b_i (rs2)
//            Memory    : data_req_o, data_gnt_i, data_addr_o, data_we_o,
//                        data_be_o, data_wdata_o, data_rvalid_i, data_rdata_i
//            WB side   : valid_o, pc_mem_o, instr_rdata_o, wb_data_o,
//                        wb_rd_o, wb_we_o, misaligned_o
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [31:0]           pc_ex_i,
  input  logic [31:0]           instr_rdata_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  output logic                  valid_o,
  output logic [31:0]           pc_mem_o,
  output logic [31:0]           instr_rdata_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_we_o,
  output logic                  misaligned_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // ---------------- EX-side decode ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [1:0] addr_lo;
  logic       is_load, is_store, is_mem, is_jump, writes_rd;
  logic       size_byte, size_half, misaligned;
  logic       accept, retire;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  assign opcode   = instr_rdata_i[6:0];
  assign rd       = instr_rdata_i[11:7];
  assign funct3   = instr_rdata_i[14:12];
  assign addr_lo  = alu_result_i[1:0];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load | is_store;
  assign is_jump  = (opcode == OPC_JAL) | (opcode == OPC_JALR);
  assign writes_rd = (opcode == OPC_OP) | (opcode == OPC_OP_IMM) |
                     (opcode == OPC_LUI) | (opcode == OPC_AUIPC) | is_jump;

  // Unsigned byte/half encodings exist only for loads; every other unknown
  // funct3 falls through to a word access.
  assign size_byte  = (funct3 == 3'b000) | (is_load & (funct3 == 3'b100));
  assign size_half  = (funct3 == 3'b001) | (is_load & (funct3 == 3'b101));
  assign misaligned = is_mem & ((size_half & addr_lo[0]) |
                                (~size_byte & ~size_half & (addr_lo != 2'b00)));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = data_b_i[31:0];
    if (size_byte) begin
      be_calc    = 4'b0001 << addr_lo;
      wdata_calc = {4{data_b_i[7:0]}};
    end else if (size_half) begin
      be_calc    = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{data_b_i[15:0]}};
    end
  end

  // ---------------- Captured access ----------------
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [31:0] req_instr;

  assign data_addr_o  = {req_addr[31:2], 2'b00};
  assign data_we_o    = req_we;
  assign data_be_o    = req_be;
  assign data_wdata_o = req_wdata;

  // ---------------- Load extraction ----------------
  logic [31:0] rshift, load_data;

  assign rshift = data_rdata_i >> {req_addr[1:0], 3'b000};

  always_comb begin
    load_data = data_rdata_i;
    case (req_instr[14:12])
      3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b100:  load_data = {24'd0, rshift[7:0]};
      3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b101:  load_data = {16'd0, rshift[15:0]};
      default: load_data = data_rdata_i;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    data_req_o = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && is_mem && !misaligned) state_next = REQ;
      end
      REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_next = RESP;
      end
      RESP: begin
        // rvalid is only honoured here, so a response arriving together
        // with the grant is dropped.
        if (data_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = valid_i & ready_o;
  assign retire = (state == RESP) & data_rvalid_i;

  // ---------------- Datapath / writeback registers ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr      <= '0;
      req_we        <= 1'b0;
      req_be        <= '0;
      req_wdata     <= '0;
      req_pc        <= '0;
      req_instr     <= '0;
      valid_o       <= 1'b0;
      pc_mem_o      <= '0;
      instr_rdata_o <= '0;
      wb_data_o     <= '0;
      wb_rd_o       <= '0;
      wb_we_o       <= 1'b0;
      misaligned_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        if (is_mem && !misaligned) begin
          req_addr  <= alu_result_i[31:0];
          req_we    <= is_store;
          req_be    <= be_calc;
          req_wdata <= wdata_calc;
          req_pc    <= pc_ex_i;
          req_instr <= instr_rdata_i;
        end else begin
          // Non-memory and misaligned instructions retire straight away.
          valid_o       <= 1'b1;
          pc_mem_o      <= pc_ex_i;
          instr_rdata_o <= instr_rdata_i;
          wb_rd_o       <= rd;
          misaligned_o  <= is_mem;
          wb_we_o       <= ~is_mem & writes_rd & (rd != 5'd0);
          wb_data_o     <= is_jump ? (pc_ex_i + 32'd4) : alu_result_i;
        end
      end else if (retire) begin
        valid_o       <= 1'b1;
        pc_mem_o      <= req_pc;
        instr_rdata_o <= req_instr;
        wb_rd_o       <= req_instr[11:7];
        misaligned_o  <= 1'b0;
        wb_we_o       <= ~req_we & (req_instr[11:7] != 5'd0);
        wb_data_o     <= req_we ? req_addr : load_data;
      end
    end
  end

endmodule
`default_nettype wire
